reg8_rr_arb: RTL and testbench

Round-robin write arbiter that shares one 8-bit enable/reset register (clk, d, en, rst -> q) among N requesters. It picks one requester at a time and steers that requester's data onto the register's d input. It pulses the register's en for exactly one cycle per accepted write and returns a one-cycle ack to the winner. It also supports locked bursts, capped at MAX_BURST writes so no requester can starve the others. The arbiter sits directly in front of the shared register, and its reg_en/reg_d outputs connect straight to the register's en/d.

---
 rtl/reg8_rr_arb_if.sv | 27 ++
 rtl/reg8_rr_arb.sv | 184 ++++++++++++++++++
 tb/tb_reg8_rr_arb.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/reg8_rr_arb_if.sv
// Bundle of request/grant and register-write signals between the requesters
// and the round-robin write arbiter that fronts the shared 8-bit register.
interface reg8_rr_arb_if #(
  parameter int N = 4,
  parameter int W = 8
);
  logic [N-1:0]   req;
  logic [N-1:0]   lock;
  logic [N*W-1:0] din;
  logic [N-1:0]   gnt;
  logic [N-1:0]   ack;
  logic           reg_en;
  logic [W-1:0]   reg_d;
  logic           busy;

  // requester side: drives requests, burst hints and data
  modport master (
    output req, lock, din,
    input  gnt, ack, reg_en, reg_d, busy
  );

  // arbiter side: consumes requests, drives grant and register write port
  modport slave (
    input  req, lock, din,
    output gnt, ack, reg_en, reg_d, busy
  );
endinterface

// File: rtl/reg8_rr_arb.sv
// Round-robin write arbiter for one shared W-bit enable/reset register.
// One owner at a time gets its data steered onto reg_d; reg_en/ack follow
// the owner's req combinationally so a write commits in the grant cycle.
// A locked owner may keep the register for up to MAX_BURST writes.
module reg8_rr_arb #(
  parameter int N         = 4,
  parameter int W         = 8,
  parameter int MAX_BURST = 4
) (
  input logic          clk,
  input logic          rst,
  reg8_rr_arb_if.slave bus
);

  localparam int IW = $clog2(N);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t        state_r, state_s;
  logic [IW-1:0] owner_r, owner_s;
  logic [IW-1:0] ptr_r,   ptr_s;
  logic [3:0]    bcnt_r,  bcnt_s;
  logic [N-1:0]  gnt_r,   gnt_s;

  logic          own_req_s;
  logic          own_lock_s;
  logic [W-1:0]  own_din_s;
  logic          rearb_s;
  logic [IW-1:0] base_s;
  logic [IW:0]   pick_s;
  logic          burst_more_s;

  // First index with a request, searching base, base+1, ... modulo N.
  // Returns {found, index}; the descending loop lets the lowest offset win.
  function automatic logic [IW:0] rr_pick(input logic [N-1:0]  req_v,
                                          input logic [IW-1:0] base_v);
    logic [IW:0] res;
    int          idx;
    res = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(base_v) + k) % N;
      if (req_v[IW'(idx)]) begin
        res = {1'b1, IW'(idx)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Index following i, wrapping at N-1 (N need not be a power of two).
  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    if (i == IW'(N - 1)) begin
      return '0;
    end else begin
      return i + 1'b1;
    end
  endfunction

  // One-hot vector with bit i set.
  function automatic logic [N-1:0] onehot(input logic [IW-1:0] i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Owner's request, lock hint and data word.
  always_comb begin
    own_req_s  = bus.req[owner_r];
    own_lock_s = bus.lock[owner_r];
    own_din_s  = '0;
    for (int i = 0; i < N; i++) begin
      if (owner_r == IW'(i)) begin
        own_din_s = bus.din[i*W +: W];
      end else begin
        own_din_s = own_din_s;
      end
    end
  end

  // Burst may continue if one more write still fits under the cap.
  always_comb begin
    burst_more_s = (({1'b0, bcnt_r} + 5'd1) < 5'(MAX_BURST));
  end

  // Next-state logic: decide hold / continue burst / re-arbitrate.
  always_comb begin
    state_s = state_r;
    owner_s = owner_r;
    ptr_s   = ptr_r;
    bcnt_s  = bcnt_r;
    gnt_s   = gnt_r;
    rearb_s = 1'b0;
    base_s  = ptr_r;

    case (state_r)
      ST_IDLE: begin
        rearb_s = 1'b1;
        base_s  = ptr_r;
      end
      ST_GRANT: begin
        if (!own_req_s) begin
          // owner withdrew before committing: rotate past it
          rearb_s = 1'b1;
          base_s  = next_idx(owner_r);
          ptr_s   = next_idx(owner_r);
        end else if (own_lock_s && burst_more_s) begin
          // committed, burst continues with the same owner
          rearb_s = 1'b0;
          bcnt_s  = bcnt_r + 4'd1;
        end else begin
          // committed, burst over: rotate past the owner
          rearb_s = 1'b1;
          base_s  = next_idx(owner_r);
          ptr_s   = next_idx(owner_r);
        end
      end
      default: begin
        state_s = ST_IDLE;
        gnt_s   = '0;
        bcnt_s  = 4'd0;
      end
    endcase

    pick_s = rr_pick(bus.req, base_s);

    if (rearb_s) begin
      if (pick_s[IW]) begin
        state_s = ST_GRANT;
        owner_s = pick_s[IW-1:0];
        gnt_s   = onehot(pick_s[IW-1:0]);
        bcnt_s  = 4'd0;
      end else begin
        state_s = ST_IDLE;
        gnt_s   = '0;
        bcnt_s  = 4'd0;
      end
    end else begin
      gnt_s = gnt_s;
    end
  end

  // State, owner, pointer, burst count and grant registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      owner_r <= '0;
      ptr_r   <= '0;
      bcnt_r  <= 4'd0;
      gnt_r   <= '0;
    end else begin
      state_r <= state_s;
      owner_r <= owner_s;
      ptr_r   <= ptr_s;
      bcnt_r  <= bcnt_s;
      gnt_r   <= gnt_s;
    end
  end

  // Register write port and ack; only live while an owner holds the grant.
  always_comb begin
    if (state_r == ST_GRANT) begin
      bus.reg_en = own_req_s;
      bus.reg_d  = own_req_s ? own_din_s : '0;
      bus.ack    = gnt_r & {N{own_req_s}};
      bus.busy   = 1'b1;
    end else begin
      bus.reg_en = 1'b0;
      bus.reg_d  = '0;
      bus.ack    = '0;
      bus.busy   = 1'b0;
    end
  end

  // Grant is driven straight from its register.
  always_comb begin
    bus.gnt = gnt_r;
  end

endmodule

// File: tb/tb_reg8_rr_arb.sv
// Directed bench for reg8_rr_arb with a model of the shared register.
module tb_reg8_rr_arb;

  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] q;

  int n_checks = 0;
  int n_fail   = 0;

  reg8_rr_arb_if #(.N(N), .W(W)) bus ();

  reg8_rr_arb #(.N(N), .W(W), .MAX_BURST(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // free-running clock, 10 time-unit period
  always #5 clk = ~clk;

  // the shared 8-bit register the arbiter writes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= '0;
    else if (bus.reg_en) q <= bus.reg_d;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance past the next rising edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int exp_g [6];
    int exp_d [6];

    rst      = 1'b0;
    bus.req  = 4'b1111;
    bus.lock = 4'b0000;
    bus.din  = '0;

    // reset holds everything idle even with requests present
    tick();
    tick();
    @(negedge clk);
    chk("rst_gnt",  32'(bus.gnt),    32'h0);
    chk("rst_busy", 32'(bus.busy),   32'h0);
    chk("rst_en",   32'(bus.reg_en), 32'h0);
    chk("rst_ack",  32'(bus.ack),    32'h0);
    chk("rst_d",    32'(bus.reg_d),  32'h0);
    bus.req = 4'b0000;
    rst     = 1'b1;

    // single requester
    tick();
    bus.req       = 4'b0001;
    bus.din[7:0]  = 8'hab;
    @(negedge clk);
    chk("t1_pre_gnt", 32'(bus.gnt),    32'h0);
    chk("t1_pre_en",  32'(bus.reg_en), 32'h0);
    tick();
    @(negedge clk);
    chk("t1_gnt",  32'(bus.gnt),    32'h1);
    chk("t1_ack",  32'(bus.ack),    32'h1);
    chk("t1_en",   32'(bus.reg_en), 32'h1);
    chk("t1_d",    32'(bus.reg_d),  32'hab);
    chk("t1_busy", 32'(bus.busy),   32'h1);
    tick();
    bus.req = 4'b0000;
    @(negedge clk);
    chk("t1_q",      32'(q),          32'hab);
    chk("t1_regrnt", 32'(bus.gnt),    32'h1);
    chk("t1_en2",    32'(bus.reg_en), 32'h0);
    chk("t1_ack2",   32'(bus.ack),    32'h0);
    tick();
    @(negedge clk);
    chk("t1_idle_gnt",  32'(bus.gnt),  32'h0);
    chk("t1_idle_busy", 32'(bus.busy), 32'h0);

    // fresh reset so the rotation starts at index 0
    rst = 1'b0;
    #1;
    rst = 1'b1;

    // round robin, all four requesting, no lock
    tick();
    bus.req = 4'b1111;
    bus.din = {8'h44, 8'h33, 8'h22, 8'h11};
    for (int k = 0; k < 5; k++) begin
      tick();
      @(negedge clk);
      chk("t2_gnt", 32'(bus.gnt),   32'(1 << (k % 4)));
      chk("t2_ack", 32'(bus.ack),   32'(1 << (k % 4)));
      chk("t2_d",   32'(bus.reg_d), 32'(8'h11 * ((k % 4) + 1)));
      if (k > 0) chk("t2_q", 32'(q), 32'(8'h11 * (((k - 1) % 4) + 1)));
    end
    tick();
    bus.req = 4'b0000;
    @(negedge clk);
    chk("t2_q_last", 32'(q),          32'h11);
    chk("t2_gnt_w",  32'(bus.gnt),    32'h2);
    chk("t2_en_w",   32'(bus.reg_en), 32'h0);
    tick();
    @(negedge clk);
    chk("t2_idle", 32'(bus.gnt), 32'h0);

    // burst cap: requester 0 locked, requester 1 waiting (pointer is at 2)
    exp_g = '{1, 1, 1, 1, 2, 1};
    exp_d = '{32'ha0, 32'ha0, 32'ha0, 32'ha0, 32'hb1, 32'ha0};
    tick();
    bus.req        = 4'b0011;
    bus.lock       = 4'b0001;
    bus.din[7:0]   = 8'ha0;
    bus.din[15:8]  = 8'hb1;
    for (int k = 0; k < 6; k++) begin
      tick();
      @(negedge clk);
      chk("t3_gnt", 32'(bus.gnt),   32'(exp_g[k]));
      chk("t3_ack", 32'(bus.ack),   32'(exp_g[k]));
      chk("t3_d",   32'(bus.reg_d), 32'(exp_d[k]));
    end
    tick();
    bus.req  = 4'b0000;
    bus.lock = 4'b0000;
    @(negedge clk);
    chk("t3_en_w", 32'(bus.reg_en), 32'h0);
    tick();
    @(negedge clk);
    chk("t3_idle", 32'(bus.gnt), 32'h0);

    // withdraw: requester 2 granted, drops before commit, 3 takes over
    tick();
    bus.req         = 4'b0100;
    bus.din[23:16]  = 8'hc2;
    tick();
    bus.req         = 4'b1000;
    bus.din[31:24]  = 8'hd3;
    @(negedge clk);
    chk("t4_gnt", 32'(bus.gnt),    32'h4);
    chk("t4_en",  32'(bus.reg_en), 32'h0);
    chk("t4_ack", 32'(bus.ack),    32'h0);
    chk("t4_d",   32'(bus.reg_d),  32'h0);
    tick();
    @(negedge clk);
    chk("t4_gnt3", 32'(bus.gnt),   32'h8);
    chk("t4_ack3", 32'(bus.ack),   32'h8);
    chk("t4_d3",   32'(bus.reg_d), 32'hd3);
    // requester 3 also withdraws before its edge: nobody left
    bus.req = 4'b0000;
    #1;
    chk("t4_en3w",  32'(bus.reg_en), 32'h0);
    chk("t4_ack3w", 32'(bus.ack),    32'h0);
    tick();
    @(negedge clk);
    chk("t4_idle", 32'(bus.busy), 32'h0);
    chk("t4_q",    32'(q),        32'ha0);

    // reset in the middle of requester 2's locked burst
    tick();
    bus.req         = 4'b0110;
    bus.lock        = 4'b0100;
    bus.din[15:8]   = 8'hc1;
    bus.din[23:16]  = 8'hc2;
    tick();
    @(negedge clk);
    chk("t5_gnt1", 32'(bus.gnt),   32'h2);
    chk("t5_d1",   32'(bus.reg_d), 32'hc1);
    tick();
    bus.req = 4'b0100;
    @(negedge clk);
    chk("t5_gnt2", 32'(bus.gnt),   32'h4);
    chk("t5_ack2", 32'(bus.ack),   32'h4);
    chk("t5_d2",   32'(bus.reg_d), 32'hc2);
    tick();
    @(negedge clk);
    chk("t5_burst", 32'(bus.gnt), 32'h4);
    #1;
    rst = 1'b0;
    #1;
    chk("t5_rst_gnt",  32'(bus.gnt),    32'h0);
    chk("t5_rst_ack",  32'(bus.ack),    32'h0);
    chk("t5_rst_en",   32'(bus.reg_en), 32'h0);
    chk("t5_rst_busy", 32'(bus.busy),   32'h0);
    chk("t5_rst_d",    32'(bus.reg_d),  32'h0);
    tick();
    rst          = 1'b1;
    bus.req      = 4'b1001;
    bus.lock     = 4'b0000;
    bus.din[7:0] = 8'hd0;
    @(negedge clk);
    chk("t5_post_idle", 32'(bus.gnt), 32'h0);
    tick();
    @(negedge clk);
    chk("t5_restart_gnt", 32'(bus.gnt),   32'h1);
    chk("t5_restart_d",   32'(bus.reg_d), 32'hd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
